// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 memory-access stage.
// Holds MAR and MDR, runs one read or write per request against a
// ready-handshaked memory port, and reports the R (memory ready) flag back
// to the control FSM.
// Optional feature: define LC3_MEM_TIMEOUT_EN to abort a request that sees
// no ready within TIMEOUT_CYCLES REQ cycles (o_err pulses with o_r).
module lc3_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ld_mar,
    input  logic [15:0] i_mar_in,
    input  logic        i_ld_mdr,
    input  logic [15:0] i_bus,
    input  logic        i_mem_en,
    input  logic        i_r_w,
    output logic [15:0] o_mar,
    output logic [15:0] o_mdr,
    output logic        o_r,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [15:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic        we;
    logic        timeout_hit;

`ifdef LC3_MEM_TIMEOUT_EN
    logic [7:0] timeout_cnt;
    logic       err;

    // The limit fires on the edge that would make the count reach
    // TIMEOUT_CYCLES; a ready on that same edge takes priority.
    assign timeout_hit = (state == REQ) && !i_mem_ready &&
                         (timeout_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Wait-cycle counter: cleared while idle, counts REQ cycles without ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timeout_cnt <= 8'd0;
        end else if (state == IDLE) begin
            timeout_cnt <= 8'd0;
        end else if (state == REQ && !i_mem_ready) begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

    // Error flag is set on the abort edge so it lines up with the DONE cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err <= 1'b0;
        end else begin
            err <= timeout_hit;
        end
    end

    assign o_err = err;
`else
    logic unused_timeout_param;

    // Without the timeout feature REQ waits for ready indefinitely.
    assign timeout_hit          = 1'b0;
    assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
    assign o_err                = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, complete or abort in REQ, one-cycle DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_mem_en) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (i_mem_ready || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // MAR/MDR/we: loadable only in IDLE so the transaction sees stable
    // values; a same-edge load and accept uses the freshly loaded values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mar <= 16'h0000;
            mdr <= 16'h0000;
            we  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_ld_mar) begin
                        mar <= i_mar_in;
                    end
                    if (i_ld_mdr) begin
                        mdr <= i_bus;
                    end
                    if (i_mem_en) begin
                        we <= i_r_w;
                    end
                end
                REQ: begin
                    if (i_mem_ready && !we) begin
                        mdr <= i_mem_rdata;
                    end else if (timeout_hit && !we) begin
                        mdr <= 16'h0000;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are register copies or decodes of the state register only.
    assign o_mar       = mar;
    assign o_mdr       = mdr;
    assign o_mem_addr  = mar;
    assign o_mem_wdata = mdr;
    assign o_mem_we    = we;
    assign o_mem_req   = (state == REQ);
    assign o_r         = (state == DONE);
    assign o_busy      = (state != IDLE);

endmodule
